// File: rtl/sym_scorer.sv
// sym_scorer: classifies player button presses against special symbols as hits, misses or false presses.
//   Clk100M, rst_n (sync, active-low)
//   genSym, generated, special, generatedSym[7:0] : symbol stream from the generator
//   btnPress                                      : debounced button level
//   score, hits, misses, falsePresses [CNT_W]     : saturating counters
//   lastSym[7:0], windowOpen                      : status
//   hitPulse, missPulse, falsePulse               : one-cycle event strobes
module sym_scorer #(
    parameter int WINDOW = 50_000_000,
    parameter int CNT_W  = 16
) (
    input  logic             Clk100M,
    input  logic             rst_n,
    input  logic             genSym,
    input  logic             generated,
    input  logic             special,
    input  logic [7:0]       generatedSym,
    input  logic             btnPress,
    output logic [CNT_W-1:0] score,
    output logic [CNT_W-1:0] hits,
    output logic [CNT_W-1:0] misses,
    output logic [CNT_W-1:0] falsePresses,
    output logic [7:0]       lastSym,
    output logic             windowOpen,
    output logic             hitPulse,
    output logic             missPulse,
    output logic             falsePulse
);
    localparam int WC_W = $clog2(WINDOW) + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] MAX = '1;
    typedef enum logic [1:0] {IDLE, WAIT, WIN} state_t;
    state_t          state;
    logic [WC_W-1:0] win_cnt;
    logic            btn_prev;
    logic            press_edge;
    logic            new_special;
    assign press_edge  = btnPress & ~btn_prev;
    assign new_special = generated & special;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == MAX) ? v : v + 1'b1;
    endfunction
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction
    always_ff @(posedge Clk100M) begin
        if (!rst_n) begin
            state        <= IDLE;
            win_cnt      <= '0;
            btn_prev     <= 1'b0;
            score        <= '0;
            hits         <= '0;
            misses       <= '0;
            falsePresses <= '0;
            lastSym      <= 8'hFF;
            windowOpen   <= 1'b0;
            hitPulse     <= 1'b0;
            missPulse    <= 1'b0;
            falsePulse   <= 1'b0;
        end else begin
            btn_prev   <= btnPress;
            hitPulse   <= 1'b0;
            missPulse  <= 1'b0;
            falsePulse <= 1'b0;
            if (!genSym) begin
                // leaving the game discards any open window without a miss
                state      <= IDLE;
                windowOpen <= 1'b0;
            end else begin
                if (generated && state != IDLE)
                    lastSym <= generatedSym;
                case (state)
                    IDLE: begin
                        state        <= WAIT;
                        score        <= '0;
                        hits         <= '0;
                        misses       <= '0;
                        falsePresses <= '0;
                        lastSym      <= 8'hFF;
                    end
                    WAIT: begin
                        if (press_edge) begin
                            falsePresses <= sat_inc(falsePresses);
                            score        <= sat_dec(score);
                            falsePulse   <= 1'b1;
                        end
                        if (new_special) begin
                            state      <= WIN;
                            win_cnt    <= '0;
                            windowOpen <= 1'b1;
                        end
                    end
                    WIN: begin
                        // a new special without a press retires the old window as a miss
                        if (press_edge) begin
                            hits       <= sat_inc(hits);
                            score      <= sat_inc(score);
                            hitPulse   <= 1'b1;
                            state      <= WAIT;
                            windowOpen <= 1'b0;
                        end else if (win_cnt == WC_LAST || new_special) begin
                            misses     <= sat_inc(misses);
                            missPulse  <= 1'b1;
                            state      <= WAIT;
                            windowOpen <= 1'b0;
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                        end
                        if (new_special) begin
                            state      <= WIN;
                            win_cnt    <= '0;
                            windowOpen <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
